// File: rtl/bus_pkg.sv
// Shared bus definitions for the L2 responder and the processor cores:
// arbiter state encoding, grant/request levels and default widths.
package bus_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_HOLD   = 8;

    localparam logic GRANTED       = 1'b1;
    localparam logic NOT_GRANTED   = 1'b0;
    localparam logic REQUESTED     = 1'b1;
    localparam logic NOT_REQUESTED = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } bus_state_t;

endpackage

// File: rtl/l2_mem.sv
// L2 storage: one synchronous write port, two zero-latency read ports.
// Contents are cleared whenever reset is asserted.
module l2_mem
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr0,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data0,
    output logic [DATA_WIDTH-1:0] rd_data1
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Reads see the old word until the write edge, then the new one.
    assign rd_data0 = mem_reg[rd_addr0];
    assign rd_data1 = mem_reg[rd_addr1];

endmodule

// File: rtl/l2_bus_responder.sv
// Two-core L2 bus responder: round-robin arbiter with a hold limit,
// and a read mux that drives the granted core's word onto data_out.
module l2_bus_responder
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  bus_request0,
    input  logic                  bus_request1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  bus_grant0,
    output logic                  bus_grant1,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  hold_timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    bus_state_t          state_reg;
    logic                grant0_reg;
    logic                grant1_reg;
    logic                timeout_reg;
    logic                last_reg;   // core served most recently (1 = core 1)
    logic                ready_reg;  // blocks granting on the first edge after reset
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic                hold_done;
    logic [DATA_WIDTH-1:0] rd_data0;
    logic [DATA_WIDTH-1:0] rd_data1;

    assign hold_done = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_reg    <= IDLE;
            grant0_reg   <= NOT_GRANTED;
            grant1_reg   <= NOT_GRANTED;
            timeout_reg  <= 1'b0;
            last_reg     <= 1'b1;
            ready_reg    <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            timeout_reg <= 1'b0;
            ready_reg   <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (ready_reg && bus_request0 == REQUESTED &&
                        (bus_request1 == NOT_REQUESTED || last_reg)) begin
                        state_reg    <= GRANT0;
                        grant0_reg   <= GRANTED;
                        last_reg     <= 1'b0;
                        hold_cnt_reg <= '0;
                    end else if (ready_reg && bus_request1 == REQUESTED) begin
                        state_reg    <= GRANT1;
                        grant1_reg   <= GRANTED;
                        last_reg     <= 1'b1;
                        hold_cnt_reg <= '0;
                    end
                end
                GRANT0: begin
                    if (bus_request0 == NOT_REQUESTED || hold_done) begin
                        state_reg   <= IDLE;
                        grant0_reg  <= NOT_GRANTED;
                        timeout_reg <= bus_request0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                GRANT1: begin
                    if (bus_request1 == NOT_REQUESTED || hold_done) begin
                        state_reg   <= IDLE;
                        grant1_reg  <= NOT_GRANTED;
                        timeout_reg <= bus_request1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    grant0_reg <= NOT_GRANTED;
                    grant1_reg <= NOT_GRANTED;
                end
            endcase
        end
    end

    l2_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk      (clk),
        .reset_in (reset_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (addr0),
        .rd_addr1 (addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1)
    );

    always_comb begin
        data_out = '0;
        case (state_reg)
            GRANT0:  data_out = rd_data0;
            GRANT1:  data_out = rd_data1;
            default: data_out = '0;
        endcase
    end

    assign bus_grant0   = grant0_reg;
    assign bus_grant1   = grant1_reg;
    assign hold_timeout = timeout_reg;

endmodule

// File: doc/l2_bus_responder.md
L2_BUS_RESPONDER -- requirements
Module: l2_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: width of the L2 word address.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: width of the L2 data word.
REQ-003 SHALL have parameter MAX_HOLD, default 8: maximum number of consecutive cycles a grant may be held.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_in, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports bus_request0 / bus_request1, input, 1 each: bus requests from core 0 and core 1.
REQ-007 SHALL have ports addr0 / addr1, input, ADDR_WIDTH each: L2 read address from each core.
REQ-008 SHALL have ports bus_grant0 / bus_grant1, output, 1 each: registered bus grants.
REQ-009 SHALL have port data_out, output, DATA_WIDTH: read data, shared by both cores' data_in.
REQ-010 SHALL have ports wr_en (1), wr_addr (ADDR_WIDTH), wr_data (DATA_WIDTH), inputs: preload/flash write port.
REQ-011 SHALL have port hold_timeout, output, 1: one-cycle pulse when a grant is force-released.

Function
REQ-012 SHALL implement arbiter FSM states IDLE, GRANT0, GRANT1.
REQ-013 IDLE with exactly one request asserted: next state SHALL be the GRANTx of the requesting core.
REQ-014 IDLE with both requests asserted: SHALL grant the core not served last (round-robin); core 0 wins first after reset.
REQ-015 bus_grant0 SHALL be 1 exactly when state == GRANT0, and bus_grant1 exactly when state == GRANT1; grants SHALL be one-hot or zero.
REQ-016 In GRANTx, when bus_requestx is sampled low, SHALL return to IDLE; the grant drops on that edge.
REQ-017 No back-to-back grants: at least one IDLE cycle SHALL separate successive grants.
REQ-018 hold_cnt SHALL be cleared on entry to GRANTx and increment each cycle in GRANTx.
REQ-019 When hold_cnt reaches MAX_HOLD-1 with the request still high, SHALL go to IDLE, pulse hold_timeout for 1 cycle, and record that core as last served.
REQ-020 data_out SHALL equal mem[addr0] in GRANT0 and mem[addr1] in GRANT1 (combinational read, zero latency), and 0 in IDLE, so an address driven in cycle N is sampled by the core at edge N+1.
REQ-021 Memory SHALL be 2^ADDR_WIDTH x DATA_WIDTH; when wr_en is high, mem[wr_addr] <= wr_data at the rising edge.
REQ-022 A write to the address currently being read SHALL show the old data before the edge and the new data after it.
REQ-023 Requests arriving mid-grant from the other core SHALL be held pending (not dropped) and served in the next IDLE.
REQ-024 Address arithmetic SHALL be unsigned; there is no wrap beyond 2^ADDR_WIDTH-1 (index width equals ADDR_WIDTH).

Reset
REQ-025 Asserting reset_in low SHALL immediately force: state IDLE, both grants 0, hold_cnt 0, hold_timeout 0, last-served = core 1 (so core 0 wins first).
REQ-026 Memory contents SHALL be cleared to 0 on reset.
REQ-027 Reset mid-grant SHALL drop the grant asynchronously; the first grant after release comes no earlier than the second rising edge.

Structure
REQ-028 State encoding, the GRANTED/NOT_GRANTED and REQUESTED/NOT_REQUESTED constants, and the width defaults SHALL live in shared package bus_pkg, shared with processor.
REQ-029 The memory array and write port SHALL be one sub-module, l2_mem; the arbiter FSM, hold counter and read mux stay in l2_bus_responder.

Verification
REQ-030 Preload mem[3]=8'h15 and mem[7]=8'h2A; core 0 requests, drives addr 3 then 7 -> grant0 one cycle after the request; data_out 8'h15 then 8'h2A; grant0 drops the cycle after the request drops.
REQ-031 Both cores request in the same cycle after reset -> grant0 first; after release, one IDLE cycle, then grant1; a second simultaneous request -> grant0 (alternates).
REQ-032 Core 1 holds its request for 12 cycles with MAX_HOLD=8 -> grant1 high for 8 cycles, hold_timeout pulses once, IDLE, then re-granted to core 1 only if core 0 is not requesting.
REQ-033 During GRANT0 with addr0=5, write mem[5]=8'hFF -> data_out shows old value until the edge, then 8'hFF.
REQ-034 Assert reset_in low mid-GRANT1 -> grant1 drops without waiting for a clock edge, data_out becomes 0, all mem reads 0 after reset.
REQ-035 No requests for 20 cycles -> both grants stay 0, data_out stays 0, and hold_timeout never pulses.
